// File: rtl/wb_bus_pkg.sv
// Shared types and constants for the Wishbone bus controller slice.
// Master count, ID width, watchdog width and controller state encoding live here.
package wb_bus_pkg;

   localparam int MASTER_COUNT    = 4;
   localparam int MASTER_ID_WIDTH = 2;
   localparam int WDOG_WIDTH      = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWNED = 2'd1,
      ST_ABORT = 2'd2
   } bus_state_t;

   typedef logic [MASTER_ID_WIDTH-1:0] master_id_t;

   function automatic logic [MASTER_COUNT-1:0] id_to_onehot(input master_id_t id);
      logic [MASTER_COUNT-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   function automatic logic [WDOG_WIDTH-1:0] sat_inc(input logic [WDOG_WIDTH-1:0] v);
      return (v == {WDOG_WIDTH{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin selector: first requester after last_id,
// searching last_id+1, +2, +3 and finally last_id itself (modulo 4).
module wb_rr_picker
   import wb_bus_pkg::*;
(
   input  logic [MASTER_COUNT-1:0] request,
   input  master_id_t              last_id,
   output logic                    valid,
   output master_id_t              next_id
);

   master_id_t w_cand;

   always_comb begin
      valid   = 1'b0;
      next_id = last_id;
      w_cand  = last_id;
      for (int i = 1; i <= MASTER_COUNT; i++) begin
         // Offset MASTER_COUNT wraps to last_id, so the previous owner is checked last.
         w_cand = last_id + master_id_t'(i);
         if (!valid && request[w_cand]) begin
            valid   = 1'b1;
            next_id = w_cand;
         end
      end
   end

endmodule

// File: rtl/wb_bus_controller.sv
// Four-master Wishbone arbiter with round-robin grant and a per-transaction
// watchdog that aborts a stalled owner with a one-cycle timeout_err pulse.
module wb_bus_controller
   import wb_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [MASTER_COUNT-1:0] m_cyc,
   input  logic                    s_ack,
   input  logic                    s_err,
   output logic [MASTER_COUNT-1:0] grant,
   output logic [MASTER_ID_WIDTH-1:0] grant_id,
   output logic                    bus_busy,
   output logic                    timeout_err,
   output logic [WDOG_WIDTH-1:0]   timeout_count
);

   localparam logic [WDOG_WIDTH-1:0] WDOG_TERM = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

   bus_state_t                r_state;
   logic [MASTER_COUNT-1:0]   r_grant;
   master_id_t                r_grant_id;
   master_id_t                r_last_id;
   logic                      r_busy;
   logic                      r_to_err;
   logic                      r_to_pend;
   logic [WDOG_WIDTH-1:0]     r_to_cnt;
   logic [WDOG_WIDTH-1:0]     r_wdog;

   logic                      w_pick_valid;
   master_id_t                w_pick_id;
   logic                      w_owner_req;
   logic                      w_term;

   wb_rr_picker u_picker (
      .request (m_cyc),
      .last_id (r_last_id),
      .valid   (w_pick_valid),
      .next_id (w_pick_id)
   );

   assign w_owner_req = m_cyc[r_grant_id];
   assign w_term      = (r_wdog == WDOG_TERM);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_grant_id <= '0;
         r_last_id  <= master_id_t'(MASTER_COUNT - 1);
         r_busy     <= 1'b0;
         r_to_err   <= 1'b0;
         r_to_pend  <= 1'b0;
         r_to_cnt   <= '0;
         r_wdog     <= '0;
      end else begin
         r_to_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_valid) begin
                  r_grant    <= id_to_onehot(w_pick_id);
                  r_grant_id <= w_pick_id;
                  r_busy     <= 1'b1;
                  r_wdog     <= '0;
                  r_state    <= ST_OWNED;
               end
            end

            ST_OWNED: begin
               // Owner release outranks both bus responses and the terminal count.
               if (!w_owner_req) begin
                  r_grant   <= '0;
                  r_busy    <= 1'b0;
                  r_last_id <= r_grant_id;
                  r_state   <= ST_IDLE;
               end else if (s_ack || s_err) begin
                  r_wdog <= '0;
               end else if (w_term) begin
                  r_to_pend <= 1'b1;
                  r_state   <= ST_ABORT;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end

            ST_ABORT: begin
               // The pulse and the count update land on the first ABORT cycle.
               if (r_to_pend) begin
                  r_to_err  <= 1'b1;
                  r_to_cnt  <= sat_inc(r_to_cnt);
                  r_to_pend <= 1'b0;
               end
               if (!w_owner_req) begin
                  r_grant   <= '0;
                  r_busy    <= 1'b0;
                  r_last_id <= r_grant_id;
                  r_state   <= ST_IDLE;
               end
            end

            default: begin
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant         = r_grant;
   assign grant_id      = r_grant_id;
   assign bus_busy      = r_busy;
   assign timeout_err   = r_to_err;
   assign timeout_count = r_to_cnt;

endmodule
